// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu: op-code map, controller states and
// width-independent helpers for sign handling.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00010;
    localparam logic [4:0] OP_OR     = 5'b00011;
    localparam logic [4:0] OP_SLL    = 5'b00100;
    localparam logic [4:0] OP_SLT    = 5'b00101;
    localparam logic [4:0] OP_XOR    = 5'b00110;
    localparam logic [4:0] OP_SRL    = 5'b00111;
    localparam logic [4:0] OP_SRA    = 5'b01000;
    localparam logic [4:0] OP_SGEU   = 5'b01101;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    // Only 10xxx codes use the iterative datapath; 11xxx finish like base ops.
    function automatic logic is_mop(input logic [4:0] op);
        return op[4] & ~op[3];
    endfunction

    function automatic logic signed_a(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic signed_b(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // A signed operand needs negating to reach its magnitude when it is negative.
    function automatic logic mag_neg(input logic sign_bit, input logic is_signed);
        return sign_bit & is_signed;
    endfunction

    // Remainder takes the dividend's sign; everything else takes the product/quotient sign.
    function automatic logic negate_result(input logic [4:0] op, input logic a_neg,
                                           input logic b_neg);
        return (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    endfunction

    // One bit of a conditional two's-complement negate: a bit flips once any
    // lower bit of the full value is set.
    function automatic logic cneg_bit(input logic x_bit, input logic neg,
                                      input logic below_set);
        return x_bit ^ (neg & below_set);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-divide step
// per cycle on a {hi, lo} accumulator, sequenced by the parent controller.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        rem_sh = {hi, lo[WIDTH-1]};
        fits   = rem_sh >= {1'b0, opnd};
        // Partial remainder stays below the divisor, so the difference fits in WIDTH bits.
        diff   = rem_sh[WIDTH-1:0] - opnd;
        if (is_div) begin
            hi_nxt = fits ? diff : rem_sh[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], fits};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
        end else if (start) begin
            hi   <= '0;
            lo   <= is_div ? op_a : op_b;
            opnd <= is_div ? op_b : op_a;
        end else if (step) begin
            hi   <= hi_nxt;
            lo   <= lo_nxt;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle base ops, WIDTH-cycle iterative
// multiply/divide through mdu_iter.
//
// state   | meaning
// IDLE    | waiting for a request
// SETUP   | load operand magnitudes into mdu_iter
// ITER    | one datapath step per cycle, cnt WIDTH-1 down to 0
// FIX     | apply result sign / special cases, register result
// DONE    | result valid, waiting for out_ready
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [SHW-1:0]   cnt;
    logic             accept;
    logic             start;
    logic             step;
    logic [2:0]       mop_sel;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             a_neg_q;
    logic             b_neg_q;
    logic             neg_q;
    logic             b_zero_q;
    logic [WIDTH-1:0] base_res;
    logic [WIDTH-1:0] fix_res;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [SHW-1:0]   shamt;

    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic neg,
                                                input logic below_set);
        logic [WIDTH-1:0] y;
        logic             seen;
        seen = below_set;
        for (int i = 0; i < WIDTH; i++) begin
            y[i] = cneg_bit(x[i], neg, seen);
            seen = seen | x[i];
        end
        return y;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state_nxt = is_mop(op) ? S_SETUP : S_DONE;
                S_SETUP: state_nxt = S_ITER;
                S_ITER:  if (cnt == '0) state_nxt = S_FIX;
                S_FIX:   state_nxt = S_DONE;
                S_DONE: begin
                    if (accept)         state_nxt = is_mop(op) ? S_SETUP : S_DONE;
                    else if (out_ready) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
        accept    = in_valid && in_ready && !flush;
        start     = (state == S_SETUP);
        step      = (state == S_ITER);
    end

    assign shamt = b[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (op)
            OP_ADD:  base_res = a + b;
            OP_SUB:  base_res = a - b;
            OP_AND:  base_res = a & b;
            OP_OR:   base_res = a | b;
            OP_SLL:  base_res = a << shamt;
            OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_XOR:  base_res = a ^ b;
            OP_SRL:  base_res = a >> shamt;
            OP_SRA:  base_res = $unsigned($signed(a) >>> shamt);
            OP_SGEU: base_res = {{(WIDTH-1){1'b0}}, (a >= b)};
            default: base_res = '0;
        endcase
    end

    assign a_mag = cneg_w(a_q, a_neg_q, 1'b0);
    assign b_mag = cneg_w(b_q, b_neg_q, 1'b0);

    // The high half of a negated product also borrows through any set bit in lo.
    always_comb begin
        fix_res = '0;
        case (mop_sel)
            3'b000:  fix_res = lo;
            3'b001,
            3'b010:  fix_res = cneg_w(hi, neg_q, |lo);
            3'b011:  fix_res = hi;
            3'b100:  fix_res = b_zero_q ? '1 : cneg_w(lo, neg_q, 1'b0);
            3'b101:  fix_res = lo;
            3'b110:  fix_res = cneg_w(hi, neg_q, 1'b0);
            3'b111:  fix_res = hi;
            default: fix_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            zero     <= 1'b1;
            cnt      <= '0;
            mop_sel  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            neg_q    <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            if (flush) begin
                result <= '0;
                zero   <= 1'b1;
            end else if (accept) begin
                if (!is_mop(op)) begin
                    result <= base_res;
                    zero   <= (base_res == '0);
                end
                mop_sel  <= op[2:0];
                a_q      <= a;
                b_q      <= b;
                a_neg_q  <= mag_neg(a[WIDTH-1], signed_a(op));
                b_neg_q  <= mag_neg(b[WIDTH-1], signed_b(op));
                neg_q    <= negate_result(op, mag_neg(a[WIDTH-1], signed_a(op)),
                                          mag_neg(b[WIDTH-1], signed_b(op)));
                b_zero_q <= (b == '0);
            end else if (state == S_FIX) begin
                result <= fix_res;
                zero   <= (fix_res == '0);
            end

            if (state == S_SETUP)
                cnt <= SHW'(WIDTH - 1);
            else if ((state == S_ITER) && (cnt != '0))
                cnt <= cnt - 1'b1;
        end
    end

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .step  (step),
        .is_div(mop_sel[2]),
        .op_a  (a_mag),
        .op_b  (b_mag),
        .hi    (hi),
        .lo    (lo)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed corner cases plus random ops checked against an
// arithmetic reference model; a WIDTH=16 instance covers the narrow build.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] result;

    logic        in_valid16, flush16, out_ready16;
    logic [4:0]  op16;
    logic [15:0] a16, b16;
    logic        in_ready16, out_valid16, zero16, busy16;
    logic [15:0] result16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
        .a(a16), .b(b16), .flush(flush16), .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .zero(zero16), .busy(busy16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model at WIDTH=32 using 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint xs, ys, xu, yu;
        logic [63:0] p;
        int sh;
        xs = longint'($signed(x));
        ys = longint'($signed(y));
        xu = longint'({32'b0, x});
        yu = longint'({32'b0, y});
        sh = int'(y[4:0]);
        case (o)
            5'b00000: return x + y;
            5'b00001: return x - y;
            5'b00010: return x & y;
            5'b00011: return x | y;
            5'b00100: return x << sh;
            5'b00101: return {31'b0, xs < ys};
            5'b00110: return x ^ y;
            5'b00111: return x >> sh;
            5'b01000: return 32'($signed(x) >>> sh);
            5'b01101: return {31'b0, x >= y};
            5'b10000: begin p = 64'(xs * ys); return p[31:0]; end
            5'b10001: begin p = 64'(xs * ys); return p[63:32]; end
            5'b10010: begin p = 64'(xs * yu); return p[63:32]; end
            5'b10011: begin p = 64'(xu * yu); return p[63:32]; end
            5'b10100: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
                return 32'(xs / ys);
            end
            5'b10101: return (y == 0) ? 32'hFFFFFFFF : x / y;
            5'b10110: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                return 32'(xs % ys);
            end
            5'b10111: return (y == 0) ? x : x % y;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // One request/response on the WIDTH=32 instance, checking latency, result and zero.
    task automatic do_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp);
        int lat;
        int exp_lat;
        exp_lat = (o[4] && !o[3]) ? 35 : 1;
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        op       = 5'($urandom);
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp);
        check({tag, " zero"}, 32'(zero), 32'(exp == 32'h0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [4:0] base_ops [10] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                  5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01101};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, y, e;
        logic [4:0]  o;
        int          lat;
        logic        seen;

        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        in_valid16 = 1'b0; flush16 = 1'b0; out_ready16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'h0);
        check("reset zero", 32'(zero), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        do_op("add ovf", 5'b00000, 32'h7FFFFFFF, 32'h1, 32'h80000000);

        // Asynchronous reset in the middle of an iterative divide.
        in_valid = 1'b1; op = 5'b10100; a = 32'd1000; b = 32'd7;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset in_ready", 32'(in_ready), 32'd1);
        check("midreset result", result, 32'h0);
        check("midreset zero", 32'(zero), 32'd1);
        check("midreset busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_op("post-reset div", 5'b10100, 32'd1000, 32'd7, 32'd142);

        do_op("sra", 5'b01000, 32'h80000000, 32'd4, 32'hF8000000);
        do_op("slt", 5'b00101, 32'hFFFFFFFF, 32'd1, 32'd1);
        do_op("mulh", 5'b10001, 32'h80000000, 32'h80000000, 32'h40000000);
        do_op("mulhu", 5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        do_op("mul", 5'b10000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB);
        do_op("div", 5'b10100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        do_op("rem", 5'b10110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        do_op("divu by0", 5'b10101, 32'h12345678, 32'd0, 32'hFFFFFFFF);
        do_op("rem by0", 5'b10110, 32'd5, 32'd0, 32'd5);
        do_op("div ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        do_op("rem ovf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0);
        do_op("div neg by0", 5'b10100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF);
        do_op("mulhsu", 5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_op("undef m", 5'b11010, 32'd9, 32'd9, 32'h0);

        // Back-to-back base ops with out_ready high: one result per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            o = base_ops[$urandom_range(0, 9)];
            x = pick();
            y = pick();
            in_valid = 1'b1; op = o; a = x; b = y;
            tick();
            check("stream out_valid", 32'(out_valid), 32'd1);
            check("stream result", result, model(o, x, y));
            check("stream in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream drain busy", 32'(busy), 32'd0);
        out_ready = 1'b0;

        // Consumer stall: result held, no new request taken until release.
        x = $urandom; y = $urandom;
        in_valid = 1'b1; op = 5'b00110; a = x; b = y;
        tick();
        in_valid = 1'b0; a = $urandom; b = $urandom;
        for (int i = 0; i < 10; i++) begin
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall result", result, x ^ y);
            check("stall in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        x = $urandom; y = $urandom;
        out_ready = 1'b1; in_valid = 1'b1; op = 5'b00000; a = x; b = y;
        #1;
        check("release in_ready", 32'(in_ready), 32'd1);
        tick();
        check("release out_valid", 32'(out_valid), 32'd1);
        check("release result", result, x + y);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;

        // Flush while iterating (counter at 10).
        in_valid = 1'b1; op = 5'b10000; a = $urandom; b = $urandom;
        tick();
        in_valid = 1'b0;
        repeat (22) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("flush no result", 32'(seen), 32'd0);

        // Flush in DONE beats both out_ready and a concurrent request.
        in_valid = 1'b1; op = 5'b00000; a = 32'd3; b = 32'd4;
        tick();
        flush = 1'b1; in_valid = 1'b1; op = 5'b00001; out_ready = 1'b0;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush done out_valid", 32'(out_valid), 32'd0);
        check("flush done busy", 32'(busy), 32'd0);
        tick();
        check("flush done no accept", 32'(out_valid), 32'd0);

        for (int i = 0; i < 150; i++) begin
            o = 5'($urandom_range(0, 31));
            x = pick();
            y = pick();
            e = model(o, x, y);
            do_op("random", o, x, y, e);
        end

        // Narrow build.
        in_valid16 = 1'b1; op16 = 5'b10011; a16 = 16'hFFFF; b16 = 16'hFFFF;
        tick();
        in_valid16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
        lat = 1;
        while (!out_valid16 && lat < 100) begin
            tick();
            lat++;
        end
        check("w16 mulhu latency", 32'(lat), 32'd19);
        check("w16 mulhu result", {16'h0, result16}, 32'h0000FFFE);
        check("w16 mulhu zero", 32'(zero16), 32'd0);
        out_ready16 = 1'b1;
        tick();
        check("w16 idle", 32'(busy16), 32'd0);
        out_ready16 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the single-cycle core ALU. It performs all base integer operations with a registered one-cycle result, and adds iterative RV32M-style multiply, divide and remainder. Multiply and divide run over WIDTH cycles on a shared shift/add datapath. The block sits in the execute stage behind a valid/ready interface, so the pipeline can stall on long operations.

## Interface
- WIDTH, 32: operand and result width; must be a power of two, ≥ 8.
- SHW, $clog2(WIDTH): shift-amount width; derived, not overridden.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request this cycle
- op  input  5  operation code, encodings in alu_pkg
- a, b  input  WIDTH  operands
- flush  input  1  abort any operation in flight
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- zero  output  1  result == 0, registered with result
- busy  output  1  state is not IDLE

One clock; reset is asynchronous and active-low.

## Operation
- Base ops (op[4]=0) keep existing encodings:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 slt (signed), 0110 xor, 0111 srl, 1000 sra, 1101 sge unsigned (a>=b → 1).
  - Shift amount is b[SHW-1:0].
  - All other op[4]=0 codes → result 0.
- M ops (op[4]=1):
  - 10000 MUL (low half), 10001 MULH (s×s), 10010 MULHSU (s×u), 10011 MULHU (u×u), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - Other op[4]=1 codes → result 0 with 1-cycle latency.
- Signed operands are converted to magnitudes in SETUP; the result sign is fixed up in FIX.
- Divide by zero: quotient = all ones, remainder = a.
- Signed overflow (a = most-negative, b = −1): quotient = a, remainder = 0.
- Zero-divisor and overflow cases still take the full latency, so timing is deterministic.
- FSM states are IDLE, SETUP, ITER, FIX, DONE.
  - IDLE + in_valid, base op → DONE.
  - IDLE + in_valid, M op → SETUP → ITER (WIDTH cycles, counter WIDTH−1 down to 0) → FIX → DONE.
  - DONE + out_ready → IDLE; or directly accept a new op if in_valid is high in the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Operands and op are captured on the accept edge; input changes afterwards have no effect.
- flush, from any state, → IDLE on the next edge. It drops out_valid, discards the result and suppresses acceptance in that cycle, even if in_valid is high. flush takes priority over out_ready.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, zero 1, busy 0, all iteration registers 0.
- Latency is counted from the accept edge to out_valid high: base op 1 cycle; M op WIDTH+3 cycles (35 at WIDTH=32).
- result and zero are stable while out_valid is high and out_ready is low. out_valid stays high until the handshake completes.
- Back-to-back base ops with out_ready held high give one result per cycle.
- Reset asserted mid-operation returns all outputs to their reset values immediately (asynchronous).

## Structure
- alu_pkg holds:
  - op-code localparams (OP_ADD … OP_REMU);
  - the state enum;
  - helper functions for magnitude and conditional negate.
- Sub-module mdu_iter holds the WIDTH-step datapath. Per cycle it does one shift-add multiply step or one restoring-divide step, and keeps a 2·WIDTH accumulator. It is controlled by the parent FSM (start, step, is_div) and outputs hi/lo halves.
- The base-op combinational datapath stays in the parent and feeds the result register.

## Test plan
- Reset with rst_n low mid-ITER → out_valid 0, in_ready 1, result 0 immediately; the next op completes normally.
- WIDTH=32:
  - add 0x7FFFFFFF+1 → 0x80000000 one cycle after accept.
  - sra 0x80000000 by 4 → 0xF8000000.
  - slt −1 vs 1 → 1.
  - back-to-back stream → one result per cycle.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MUL −3×7 → 0xFFFFFFEB. Each takes exactly 35 cycles.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU x/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM 0x80000000/−1 → 0.
- out_ready held low 10 cycles after a result → result and out_valid held; in_ready 0 until release. A new op offered in the release cycle is accepted.
- flush asserted at ITER counter 10 → IDLE next cycle, no out_valid. Also run at WIDTH=16 with MULHU 0xFFFF×0xFFFF → 0xFFFE after 19 cycles.
